sma_trade_signal: RTL and testbench

SMA_TRADE_SIGNAL -- requirements
Module: sma_trade_signal

---
 rtl/sma_trade_signal_if.sv | 35 +++
 rtl/sma_trade_signal.sv | 148 ++++++++++++++
 tb/tb_sma_trade_signal.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sma_trade_signal_if.sv
`default_nettype none
// ============================================================================
//  Module      : sma_trade_signal_if
//  Description : Bundle of the sample-in and order-out handshakes of the
//                SMA crossover trade-signal block, plus its status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface sma_trade_signal_if #(
    parameter int DATA_W = 18
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_price;
    logic [DATA_W-1:0] in_avg;
    logic              in_avg_full;
    logic              order_valid;
    logic              order_ready;
    logic              order_side;
    logic [DATA_W-1:0] order_price;
    logic [1:0]        position;
    logic [15:0]       trade_count;

    // Upstream SMA stage / execution side
    modport master (
        output in_valid, in_price, in_avg, in_avg_full, order_ready,
        input  in_ready, order_valid, order_side, order_price, position, trade_count
    );

    // Trade-signal block side
    modport slave (
        input  in_valid, in_price, in_avg, in_avg_full, order_ready,
        output in_ready, order_valid, order_side, order_price, position, trade_count
    );
endinterface
`default_nettype wire

// File: rtl/sma_trade_signal.sv
`default_nettype none
// ============================================================================
//  Module      : sma_trade_signal
//  Description : Compares price against its moving average with hysteresis
//                and issues buy/sell orders that move a FLAT/LONG/SHORT
//                position, with a post-order cooldown.
//  Revision    : 1.0  initial release
// ============================================================================
module sma_trade_signal #(
    parameter int DATA_W   = 18,
    parameter int THRESH   = 4,
    parameter int COOLDOWN = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sma_trade_signal_if.slave bus
);
    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] c_COOLDOWN = CD_W'(COOLDOWN);

    localparam logic [1:0] c_FLAT  = 2'b00;
    localparam logic [1:0] c_LONG  = 2'b01;
    localparam logic [1:0] c_SHORT = 2'b10;

    // One extra bit beyond the difference so +/-THRESH never overflows.
    localparam logic signed [DATA_W+1:0] c_THRESH_POS = (DATA_W+2)'(THRESH);
    localparam logic signed [DATA_W+1:0] c_THRESH_NEG = -c_THRESH_POS;

    logic [1:0]        position_q, position_d;
    logic              order_valid_q, order_valid_d;
    logic              order_side_q, order_side_d;
    logic [DATA_W-1:0] order_price_q, order_price_d;
    logic [15:0]       trade_count_q, trade_count_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;

    logic                     w_accept;
    logic                     w_handshake;
    logic signed [DATA_W:0]   w_diff;
    logic signed [DATA_W+1:0] w_diff_ext;
    logic                     w_bull;
    logic                     w_bear;
    logic                     w_buy;
    logic                     w_sell;
    logic                     w_decide;

    assign w_accept    = bus.in_valid & ~order_valid_q;
    assign w_handshake = order_valid_q & bus.order_ready;

    // Both operands zero-extended, so the signed difference cannot wrap.
    assign w_diff     = $signed({1'b0, bus.in_price}) - $signed({1'b0, bus.in_avg});
    assign w_diff_ext = {w_diff[DATA_W], w_diff};
    assign w_bull     = (w_diff_ext > c_THRESH_POS);
    assign w_bear     = (w_diff_ext < c_THRESH_NEG);

    // Position state register; only a completed order moves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position_q <= c_FLAT;
        end else begin
            position_q <= position_d;
        end
    end

    // Position next state: a buy closes a short or opens a long, a sell the reverse.
    always_comb begin
        position_d = position_q;
        if (w_handshake) begin
            case (position_q)
                c_FLAT:  position_d = order_side_q ? c_LONG : c_SHORT;
                c_LONG:  position_d = order_side_q ? c_LONG : c_FLAT;
                c_SHORT: position_d = order_side_q ? c_FLAT : c_SHORT;
                default: position_d = c_FLAT;
            endcase
        end
    end

    // Position-dependent trade decision for the sample at the input.
    always_comb begin
        w_buy  = 1'b0;
        w_sell = 1'b0;
        case (position_q)
            c_FLAT: begin
                w_buy  = w_bull;
                w_sell = w_bear;
            end
            c_LONG:  w_sell = w_bear;
            c_SHORT: w_buy  = w_bull;
            default: begin
                w_buy  = 1'b0;
                w_sell = 1'b0;
            end
        endcase
    end

    // A sample only yields an order once the average is valid and cooldown has expired.
    assign w_decide = w_accept & bus.in_avg_full & (cooldown_q == '0) & (w_buy | w_sell);

    // Order holding register, trade counter and cooldown next-state.
    always_comb begin
        order_valid_d = order_valid_q;
        order_side_d  = order_side_q;
        order_price_d = order_price_q;
        trade_count_d = trade_count_q;
        cooldown_d    = cooldown_q;
        if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
        end
        if (w_handshake) begin
            order_valid_d = 1'b0;
            cooldown_d    = c_COOLDOWN;
            if (trade_count_q != 16'hFFFF) begin
                trade_count_d = trade_count_q + 16'd1;
            end
        end
        // Cannot coincide with a handshake: no sample is accepted while an order is pending.
        if (w_decide) begin
            order_valid_d = 1'b1;
            order_side_d  = w_buy;
            order_price_d = bus.in_price;
        end
    end

    // Order, counter and cooldown registers; reset discards any pending order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_valid_q <= 1'b0;
            order_side_q  <= 1'b0;
            order_price_q <= '0;
            trade_count_q <= '0;
            cooldown_q    <= '0;
        end else begin
            order_valid_q <= order_valid_d;
            order_side_q  <= order_side_d;
            order_price_q <= order_price_d;
            trade_count_q <= trade_count_d;
            cooldown_q    <= cooldown_d;
        end
    end

    assign bus.in_ready    = ~order_valid_q;
    assign bus.order_valid = order_valid_q;
    assign bus.order_side  = order_side_q;
    assign bus.order_price = order_price_q;
    assign bus.position    = position_q;
    assign bus.trade_count = trade_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sma_trade_signal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sma_trade_signal
//  Description : Self-checking bench for sma_trade_signal: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sma_trade_signal;
    localparam int DATA_W   = 18;
    localparam int THRESH   = 4;
    localparam int COOLDOWN = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sma_trade_signal_if #(.DATA_W(DATA_W)) ifc ();

    sma_trade_signal #(
        .DATA_W  (DATA_W),
        .THRESH  (THRESH),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_valid;
    bit m_side;
    int m_price;
    int m_pos;    // 0 FLAT, 1 LONG, 2 SHORT
    int m_count;
    int m_cd;

    // 0 = no order, 1 = buy, 2 = sell
    function automatic int decide(int pos, int price, int avg);
        int  diff;
        bit  bull;
        bit  bear;
        diff = price - avg;
        bull = diff > THRESH;
        bear = diff < -THRESH;
        if (pos == 0) return bull ? 1 : (bear ? 2 : 0);
        if (pos == 1) return bear ? 2 : 0;
        if (pos == 2) return bull ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_side = 0; m_price = 0; m_pos = 0; m_count = 0; m_cd = 0;
    endtask

    // One rising edge: advance the model from the inputs seen at that edge.
    task automatic tick();
        bit acc;
        bit hs;
        int d;
        @(posedge clk);
        if (!rst) begin
            acc = ifc.in_valid && !m_valid;
            hs  = m_valid && ifc.order_ready;
            d   = (acc && ifc.in_avg_full && m_cd == 0) ?
                  decide(m_pos, int'(ifc.in_price), int'(ifc.in_avg)) : 0;
            if (hs) begin
                m_valid = 0;
                if (m_side) m_pos = (m_pos == 2) ? 0 : 1;
                else        m_pos = (m_pos == 1) ? 0 : 2;
                if (m_count < 65535) m_count++;
                m_cd = COOLDOWN;
            end else if (m_cd > 0) begin
                m_cd--;
            end
            if (d != 0) begin
                m_valid = 1;
                m_side  = (d == 1);
                m_price = int'(ifc.in_price);
            end
        end
        #1;
    endtask

    task automatic set_sample(bit v, int price, int avg, bit full);
        ifc.in_valid    = v;
        ifc.in_price    = DATA_W'(price);
        ifc.in_avg      = DATA_W'(avg);
        ifc.in_avg_full = full;
    endtask

    task automatic idle(int n);
        ifc.in_valid    = 1'b0;
        ifc.order_ready = 1'b1;
        repeat (n) tick();
        ifc.order_ready = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #4;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_sample(0, 0, 0, 0);
        ifc.order_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        n_checks++; if (ifc.order_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", ifc.order_valid); end
        n_checks++; if (ifc.position !== 2'b00) begin n_fail++; $display("FAIL reset_pos got=%0b exp=00", ifc.position); end
        n_checks++; if (ifc.trade_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ifc.trade_count); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", ifc.in_ready); end
        n_checks++; if (ifc.order_price !== '0 || ifc.order_side !== 1'b0) begin n_fail++; $display("FAIL reset_order got=%0d/%0b exp=0/0", ifc.order_price, ifc.order_side); end
        rst = 1'b0;
    endtask

    task automatic test_buy_basic();
        set_sample(1, 1010, 1000, 1);
        ifc.order_ready = 1'b0;
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1) begin n_fail++; $display("FAIL buy_valid got=%0b exp=1", ifc.order_valid); end
        n_checks++; if (ifc.order_side !== 1'b1) begin n_fail++; $display("FAIL buy_side got=%0b exp=1", ifc.order_side); end
        n_checks++; if (ifc.order_price !== 18'd1010) begin n_fail++; $display("FAIL buy_price got=%0d exp=1010", ifc.order_price); end
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL buy_ready got=%0b exp=0", ifc.in_ready); end
        ifc.order_ready = 1'b1;
        tick();
        n_checks++; if (ifc.position !== 2'b01) begin n_fail++; $display("FAIL buy_pos got=%0b exp=01", ifc.position); end
        n_checks++; if (ifc.trade_count !== 16'd1) begin n_fail++; $display("FAIL buy_count got=%0d exp=1", ifc.trade_count); end
        n_checks++; if (ifc.order_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL buy_release got=%0b/%0b exp=0/1", ifc.order_valid, ifc.in_ready); end
        idle(10);
    endtask

    task automatic test_cooldown();
        bit seen;
        set_sample(1, 990, 1000, 1);
        ifc.order_ready = 1'b0;
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b0) begin n_fail++; $display("FAIL cd_sell got=%0b/%0b exp=1/0", ifc.order_valid, ifc.order_side); end
        ifc.order_ready = 1'b1;
        tick();
        ifc.order_ready = 1'b0;
        n_checks++; if (ifc.position !== 2'b00) begin n_fail++; $display("FAIL cd_flat got=%0b exp=00", ifc.position); end
        set_sample(1, 1010, 1000, 1);
        seen = 0;
        for (int i = 0; i < COOLDOWN; i++) begin
            tick();
            if (ifc.order_valid !== 1'b0) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cd_suppress got=%0b exp=0", seen); end
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b1) begin n_fail++; $display("FAIL cd_rebuy got=%0b/%0b exp=1/1", ifc.order_valid, ifc.order_side); end
        ifc.order_ready = 1'b1;
        tick();
        n_checks++; if (ifc.position !== 2'b01 || ifc.trade_count !== 16'd3) begin n_fail++; $display("FAIL cd_after got=%0b/%0d exp=01/3", ifc.position, ifc.trade_count); end
        idle(10);
    endtask

    task automatic test_backpressure();
        bit bad;
        set_sample(1, 990, 1000, 1);
        ifc.order_ready = 1'b0;
        tick();
        set_sample(1, 500, 1000, 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b0 || ifc.order_price !== 18'd990 ||
                ifc.in_ready !== 1'b0 || ifc.position !== 2'b01) bad = 1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL bp_stable got=%0b/%0b/%0d/%0b exp=1/0/990/0", ifc.order_valid, ifc.order_side, ifc.order_price, ifc.in_ready); end
        ifc.in_valid    = 1'b0;
        ifc.order_ready = 1'b1;
        tick();
        n_checks++; if (ifc.position !== 2'b00 || ifc.trade_count !== 16'd4) begin n_fail++; $display("FAIL bp_hs got=%0b/%0d exp=00/4", ifc.position, ifc.trade_count); end
        n_checks++; if (ifc.order_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got=%0b exp=0", ifc.order_valid); end
        idle(10);
    endtask

    task automatic test_threshold();
        set_sample(1, 1004, 1000, 1);
        tick();
        n_checks++; if (ifc.order_valid !== 1'b0) begin n_fail++; $display("FAIL th_pos_edge got=%0b exp=0", ifc.order_valid); end
        set_sample(1, 996, 1000, 1);
        tick();
        n_checks++; if (ifc.order_valid !== 1'b0) begin n_fail++; $display("FAIL th_neg_edge got=%0b exp=0", ifc.order_valid); end
        set_sample(1, 1005, 1000, 1);
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b1 || ifc.order_price !== 18'd1005) begin n_fail++; $display("FAIL th_buy got=%0b/%0b/%0d exp=1/1/1005", ifc.order_valid, ifc.order_side, ifc.order_price); end
        ifc.order_ready = 1'b1;
        tick();
        n_checks++; if (ifc.position !== 2'b01 || ifc.trade_count !== 16'd5) begin n_fail++; $display("FAIL th_after got=%0b/%0d exp=01/5", ifc.position, ifc.trade_count); end
        idle(10);
    endtask

    task automatic test_avgfull_nowrap();
        do_reset();
        set_sample(1, 2000, 0, 0);
        tick();
        n_checks++; if (ifc.order_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL notfull got=%0b/%0b exp=0/1", ifc.order_valid, ifc.in_ready); end
        set_sample(1, 0, 262143, 1);
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b0 || ifc.order_price !== 18'd0) begin n_fail++; $display("FAIL nowrap_sell got=%0b/%0b/%0d exp=1/0/0", ifc.order_valid, ifc.order_side, ifc.order_price); end
        ifc.order_ready = 1'b1;
        tick();
        n_checks++; if (ifc.position !== 2'b10 || ifc.trade_count !== 16'd1) begin n_fail++; $display("FAIL nowrap_short got=%0b/%0d exp=10/1", ifc.position, ifc.trade_count); end
        idle(10);
    endtask

    task automatic test_random();
        int base;
        logic [40:0] got;
        logic [40:0] exp;
        for (int i = 0; i < 400; i++) begin
            base = int'($urandom_range(1000, 3000));
            set_sample($urandom_range(0, 3) != 0, base + int'($urandom_range(0, 20)) - 10, base,
                       $urandom_range(0, 6) != 0);
            ifc.order_ready = ($urandom_range(0, 4) > 1);
            tick();
            got = {ifc.order_valid, ifc.order_side, ifc.order_price, ifc.position, ifc.trade_count, ifc.in_ready};
            exp = {m_valid, m_side, DATA_W'(m_price), 2'(m_pos), 16'(m_count), !m_valid};
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL random cycle=%0d got=%h exp=%h", i, got, exp); end
        end
        idle(10);
    endtask

    task automatic test_reset_mid_order();
        do_reset();
        set_sample(1, 1010, 1000, 1);
        ifc.order_ready = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        idle(10);
        set_sample(1, 990, 1000, 1);
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.trade_count !== 16'd1 || ifc.position !== 2'b01) begin n_fail++; $display("FAIL mid_setup got=%0b/%0d/%0b exp=1/1/01", ifc.order_valid, ifc.trade_count, ifc.position); end
        ifc.order_ready = 1'b1;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (ifc.order_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%0b exp=0", ifc.order_valid); end
        n_checks++; if (ifc.position !== 2'b00 || ifc.trade_count !== 16'd0) begin n_fail++; $display("FAIL mid_state got=%0b/%0d exp=00/0", ifc.position, ifc.trade_count); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%0b exp=1", ifc.in_ready); end
        #2;
        rst = 1'b0;
        ifc.order_ready = 1'b0;
        set_sample(1, 1010, 1000, 1);
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.order_valid !== 1'b1 || ifc.order_side !== 1'b1) begin n_fail++; $display("FAIL first_after_rst got=%0b/%0b exp=1/1", ifc.order_valid, ifc.order_side); end
    endtask

    initial begin
        test_reset();
        test_buy_basic();
        test_cooldown();
        test_backpressure();
        test_threshold();
        test_avgfull_nowrap();
        test_random();
        test_reset_mid_order();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
